parity_scheduler: RTL and testbench
===================================

PARITY_SCHEDULER -- requirements
Module: parity_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the parity engine, range 2..8.
REQ-002 Parameter DATA_W, default 32: request word width; SHALL be a multiple of SLICE_W.
REQ-003 Parameter SLICE_W, default 8: bits folded into the parity accumulator per cycle.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port req_valid, input, NUM_REQ: per-requester request pending.
REQ-007 Port req_data, input, NUM_REQ*DATA_W: requester k's word in bits [k*DATA_W +: DATA_W].
REQ-008 Port req_ready, output, NUM_REQ: one-hot or zero; grant/accept strobe to requester.
REQ-009 Port rsp_valid, output, 1: result available.
REQ-010 Port rsp_ready, input, 1: consumer accepts result.
REQ-011 Port rsp_id, output, clog2(NUM_REQ): index of the requester whose word produced the result.
REQ-012 Port rsp_parity, output, 1: even-parity bit (XOR of all DATA_W bits) of the accepted word.

Function
REQ-013 FSM states SHALL be IDLE, CALC and RESP.
REQ-014 In IDLE, req_ready SHALL be driven combinationally high for exactly one requester: the first asserted req_valid found searching upward from rr_ptr, with wrap-around; all bits are 0 when no req_valid is asserted.
REQ-015 Handshake: a request SHALL be accepted on an edge where req_valid[k] and req_ready[k] are both high; on acceptance, latch the word and id, clear the accumulator and slice counter, and go to CALC.
REQ-016 req_ready SHALL be all-zero in CALC and RESP; requesters hold req_valid/req_data until accepted, and deasserting before acceptance is legal and causes no grant.
REQ-017 In CALC, each cycle SHALL XOR-reduce slice[cnt] (SLICE_W bits, LSB slice first) into the accumulator and increment cnt.
REQ-018 After DATA_W/SLICE_W CALC cycles (4 by default), the FSM SHALL enter RESP.
REQ-019 In RESP, rsp_valid SHALL be 1, with rsp_id and rsp_parity stable until the edge with rsp_ready=1. That edge SHALL set rr_ptr = (granted id + 1) mod NUM_REQ and return to IDLE.
REQ-020 Latency: with acceptance at edge t, rsp_valid SHALL first be high in the cycle after edge t+DATA_W/SLICE_W (5 cycles after the accept cycle by default).
REQ-021 Minimum issue interval SHALL be DATA_W/SLICE_W+2 cycles (6 by default) with rsp_ready held high.
REQ-022 Fairness: with all requesters continuously valid, grants SHALL rotate 0,1,2,...,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 other grants.
REQ-023 rsp_ready high outside RESP SHALL have no effect; rsp_valid SHALL never be high outside RESP.
REQ-024 Changes on req_data after acceptance SHALL not affect the in-flight result.

Reset
REQ-025 While reset=1 at an edge, the FSM SHALL go to IDLE, rr_ptr to 0, cnt to 0 and the accumulator to 0; rsp_valid, rsp_id and rsp_parity SHALL read 0.
REQ-026 req_ready SHALL be all-zero during any cycle in which reset is high.
REQ-027 Reset asserted in CALC or RESP SHALL abort the in-flight request with no response; the requester is not re-granted automatically.

Structure
REQ-028 Package parity_scheduler_pkg SHALL hold the FSM state typedef and the default values of NUM_REQ, DATA_W and SLICE_W.
REQ-029 Round-robin grant selection SHALL live in sub-module rr_arbiter (inputs: req vector and ptr; output: one-hot grant and index).

Verification
REQ-030 Single request: req_valid=4'b0001, data 32'h0000_0001, rsp_ready=1 -> rsp_valid 5 cycles after accept, rsp_id=0, rsp_parity=1.
REQ-031 Parity values: 32'hFFFF_FFFF -> 0; 32'h8000_0003 -> 1; 32'h0000_0000 -> 0; 32'h0100_0000 -> 1 (top slice exercised).
REQ-032 Round-robin: all four requesters valid continuously -> rsp_id sequence 0,1,2,3,0; issue interval exactly 6 cycles.
REQ-033 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_parity held stable, req_ready all-zero, and the next grant only after the rsp_ready edge.
REQ-034 Mid-op reset: reset for 1 cycle during the 2nd CALC cycle -> no rsp_valid; rr_ptr=0, so with requesters 2 and 0 valid the next grant goes to 0.
REQ-035 Data change after accept: alter req_data[k] during CALC -> result matches the word captured at acceptance.

Source files
------------

// File: rtl/parity_scheduler_pkg.sv
// Shared defaults and FSM state type for the round-robin parity scheduler.
package parity_scheduler_pkg;

    localparam int unsigned NUM_REQ_DEFAULT = 4;
    localparam int unsigned DATA_W_DEFAULT  = 32;
    localparam int unsigned SLICE_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/parity_scheduler_rr_arbiter.sv
// Round-robin selector: the first asserted request at or above ptr, wrapping around.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/parity_scheduler.sv
// Shares one slice-serial parity engine among NUM_REQ requesters with
// round-robin grants and a valid/ready response port.
module parity_scheduler
    import parity_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned SLICE_W = SLICE_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic                         rsp_parity
);

    localparam int unsigned IDX_W      = $clog2(NUM_REQ);
    localparam int unsigned NUM_SLICES = DATA_W / SLICE_W;
    localparam int unsigned CNT_W      = $clog2(NUM_SLICES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);
    localparam logic [IDX_W-1:0] LAST_ID  = IDX_W'(NUM_REQ - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_q, acc_d;
    logic               rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [DATA_W-1:0]  word_sel;
    logic               accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grant is only offered while idle and out of reset; grant already implies valid.
    always_comb begin
        req_ready = (state_q == IDLE && !reset) ? grant : '0;
        accept    = |req_ready;
    end

    always_comb begin
        word_sel = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                word_sel = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // The captured word is shifted down each CALC cycle so slice[cnt] is always the low slice.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d  = word_sel;
                    id_d    = grant_idx;
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d  = acc_q ^ (^word_q[SLICE_W-1:0]);
                word_d = word_q >> SLICE_W;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (id_q == LAST_ID) ? '0 : id_q + IDX_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            word_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_parity = acc_q;

endmodule

// File: tb/tb_parity_scheduler.sv
// Randomized and directed bench for parity_scheduler against a transaction-level model.
module tb_parity_scheduler;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int SW = 8;
    localparam int NS = DW / SW;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic              rsp_parity;

    parity_scheduler #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .SLICE_W (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_parity (rsp_parity)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: in-flight transaction with its age in edges since acceptance.
    bit            m_known = 0;
    bit            m_busy  = 0;
    int            m_ptr   = 0;
    int            m_id    = 0;
    int            m_age   = 0;
    bit            m_par   = 0;
    bit            m_after_reset = 0;
    logic [NR-1:0] m_exp_ready = '0;

    bit obs_valid = 0;
    int obs_id    = 0;
    bit obs_par   = 0;
    int chk_cycle = 0;
    bit acc_flag  = 0;
    int acc_id    = 0;
    bit rsp_fired = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [NR-1:0] model_grant();
        logic [NR-1:0] g = '0;
        for (int i = 0; i < NR; i++) begin
            int k = (m_ptr + i) % NR;
            if (g == '0 && req_valid[k]) g[k] = 1'b1;
        end
        return g;
    endfunction

    task automatic check_outputs();
        bit exp_v;
        m_exp_ready = (reset || m_busy) ? '0 : model_grant();
        exp_v = m_busy && (m_age >= NS);
        chk("req_ready", 32'(req_ready), 32'(m_exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (exp_v) begin
            chk("rsp_id", 32'(rsp_id), m_id);
            chk("rsp_parity", 32'(rsp_parity), 32'(m_par));
        end
        if (m_after_reset) begin
            chk("reset_rsp_id", 32'(rsp_id), 0);
            chk("reset_rsp_parity", 32'(rsp_parity), 0);
        end
        obs_valid = rsp_valid;
        obs_id    = int'(rsp_id);
        obs_par   = rsp_parity;
        chk_cycle = cyc;
    endtask

    task automatic model_edge();
        acc_flag  = 0;
        rsp_fired = 0;
        if (reset) begin
            m_busy = 0;
            m_ptr  = 0;
            m_after_reset = 1;
        end else begin
            m_after_reset = 0;
            if (!m_busy) begin
                for (int k = 0; k < NR; k++) begin
                    if (m_exp_ready[k]) begin
                        m_busy   = 1;
                        m_id     = k;
                        m_par    = bit'($countones(req_data[k*DW +: DW]) % 2);
                        m_age    = 0;
                        acc_flag = 1;
                        acc_id   = k;
                    end
                end
            end else if (m_age >= NS && rsp_ready) begin
                m_busy    = 0;
                m_ptr     = (m_id + 1) % NR;
                rsp_fired = 1;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic tick();
        #1;
        if (m_known) check_outputs();
        else m_exp_ready = '0;
        model_edge();
        if (reset) m_known = 1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_word(int k, logic [31:0] w);
        req_data[k*DW +: DW] = w;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        case ($urandom_range(0, 7))
            0: w = '0;
            1: w = '1;
            2: w = 32'h1 << $urandom_range(0, 31);
            default: w = $urandom;
        endcase
        return w;
    endfunction

    task automatic do_reset(int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && m_busy; i++) tick();
    endtask

    task automatic wait_accept(string tag, output bit got, output int a, output int id);
        got = 0; a = 0; id = -1;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (acc_flag) begin
                got = 1; a = chk_cycle; id = acc_id;
            end
        end
        chk({tag, "_accept"}, 32'(got), 1);
    endtask

    // One lone requester; latency, id and parity are hand-computed literals.
    task automatic single(int k, logic [31:0] w, bit exp_par, string tag);
        bit got, seen, done;
        int a, r, id, sid;
        bit spar;
        seen = 0; done = 0; r = -100; sid = -1; spar = 0;
        req_valid = '0;
        req_valid[k] = 1'b1;
        set_word(k, w);
        rsp_ready = 1'b1;
        wait_accept(tag, got, a, id);
        req_valid = '0;
        set_word(k, ~w);
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (obs_valid && !seen) begin
                seen = 1; r = chk_cycle; sid = obs_id; spar = obs_par;
            end
            if (rsp_fired) done = 1;
        end
        chk({tag, "_latency"}, r - a, 5);
        chk({tag, "_id"}, sid, k);
        chk({tag, "_parity"}, 32'(spar), 32'(exp_par));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int a, id, held, fired_cnt, stray, vcount;
        int ids[$];
        int cycs[$];
        int exp_ids[5] = '{0, 1, 2, 3, 0};

        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        do_reset(3);

        single(0, 32'h0000_0001, 1'b1, "single");
        single(1, 32'hFFFF_FFFF, 1'b0, "par_ones");
        single(2, 32'h8000_0003, 1'b1, "par_8003");
        single(3, 32'h0000_0000, 1'b0, "par_zero");
        single(0, 32'h0100_0000, 1'b1, "par_top");

        // Pointer now 1: without the pointer reset, requester 2 would win next.
        req_valid = 4'b0100;
        set_word(2, 32'h1234_5678);
        wait_accept("midrst_first", got, a, id);
        req_valid = '0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            vcount += int'(obs_valid);
        end
        chk("midrst_no_rsp", vcount, 0);
        req_valid = 4'b0101;
        set_word(0, 32'h0000_0003);
        wait_accept("midrst_second", got, a, id);
        chk("midrst_grant_id", id, 0);
        drain();

        do_reset(2);
        rsp_ready = 1'b1;
        for (int k = 0; k < NR; k++) set_word(k, rand_word());
        req_valid = '1;
        for (int i = 0; i < 60 && ids.size() < 5; i++) begin
            tick();
            if (acc_flag) begin
                ids.push_back(acc_id);
                cycs.push_back(chk_cycle);
                set_word(acc_id, rand_word());
            end
        end
        for (int j = 0; j < 5; j++)
            chk("rr_id", (j < ids.size()) ? ids[j] : -1, exp_ids[j]);
        for (int j = 1; j < 5; j++)
            chk("rr_interval", (j < cycs.size()) ? cycs[j] - cycs[j-1] : -1, 6);
        drain();

        req_valid = 4'b0010;
        set_word(1, 32'h0000_0007);
        rsp_ready = 1'b0;
        wait_accept("bp", got, a, id);
        req_valid = 4'b0100;
        set_word(2, 32'h0F0F_0F0F);
        for (int i = 0; i < 12 && !obs_valid; i++) tick();
        chk("bp_rsp_seen", 32'(obs_valid), 1);
        held = 0; stray = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            held  += int'(obs_valid);
            stray += int'(acc_flag);
        end
        chk("bp_held", held, 9);
        chk("bp_no_grant", stray, 0);
        rsp_ready = 1'b1;
        tick();
        chk("bp_release", 32'(rsp_fired), 1);
        tick();
        chk("bp_next_grant", acc_flag ? acc_id : -1, 2);
        drain();

        fired_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            rsp_ready = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < NR; k++) begin
                if (!req_valid[k]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_valid[k] = 1'b1;
                        set_word(k, rand_word());
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
            tick();
            fired_cnt += int'(rsp_fired);
            if (acc_flag) begin
                req_valid[acc_id] = 1'($urandom_range(0, 1));
                set_word(acc_id, rand_word());
            end
        end
        reset = 1'b0;
        chk("random_activity", 32'(fired_cnt > 100), 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
